// File: rtl/sram_exp_pkg.sv
// Shared definitions for the FP32 exp() SRAM lookup tables.
// The table index layout is {E_adj, mantissa slice, sign}. The write side
// and any later readback block share these constants and the FSM state type.
package sram_exp_pkg;

    localparam int EMIN    = -7;
    localparam int EMAX    = 6;
    localparam int E_ADJ_W = 4;
    localparam int HI_M_W  = 11;
    localparam int LO_M_W  = 12;

    localparam int HI_AW_DEF = E_ADJ_W + HI_M_W + 1;
    localparam int LO_AW_DEF = E_ADJ_W + LO_M_W + 1;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_HI = 2'd1,
        ST_LOAD_LO = 2'd2,
        ST_DONE    = 2'd3
    } wr_state_t;

endpackage

// File: rtl/sram_exp_table_writer_if.sv
// Valid/ready entry stream feeding the exp() table writer.
// The host drives entries through the master modport. The writer takes them
// through the slave modport.
interface sram_exp_table_writer_if
    import sram_exp_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sram_exp_table_writer.sv
// Write side of the FP32 exp() lookup tables.
// The writer takes the entry stream and writes the HI table first, then the LO
// table, each in address order. It keeps a running checksum for each table.
// done marks a complete image, and the lookup path waits for it.
module sram_exp_table_writer
    import sram_exp_pkg::*;
#(
    parameter int HI_AW = HI_AW_DEF,
    parameter int LO_AW = LO_AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    sram_exp_table_writer_if.slave s_if,
    output logic                  hi_we,
    output logic [HI_AW-1:0]      hi_addr,
    output logic [DW-1:0]         hi_wdata,
    output logic                  lo_we,
    output logic [LO_AW-1:0]      lo_addr,
    output logic [DW-1:0]         lo_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           hi_sum,
    output logic [31:0]           lo_sum
);

    // One counter serves both tables, so it must span the wider address.
    localparam int CW = (HI_AW > LO_AW) ? HI_AW : LO_AW;
    localparam logic [CW-1:0] HI_LAST = CW'((64'd1 << HI_AW) - 64'd1);
    localparam logic [CW-1:0] LO_LAST = CW'((64'd1 << LO_AW) - 64'd1);

    wr_state_t     state;
    wr_state_t     state_nxt;
    logic [CW-1:0] addr_cnt;
    logic          xfer;
    logic          xfer_hi;
    logic          xfer_lo;
    logic          hi_last;
    logic          lo_last;
    logic          load_begin;

    // ready comes only from the state register. This keeps it free of any
    // combinational path from valid, and it stays high across the HI->LO step.
    assign busy        = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
    assign s_if.s_ready = busy;
    assign xfer        = s_if.s_valid & busy;
    assign xfer_hi     = xfer && (state == ST_LOAD_HI);
    assign xfer_lo     = xfer && (state == ST_LOAD_LO);
    assign hi_last     = xfer_hi && (addr_cnt == HI_LAST);
    assign lo_last     = xfer_lo && (addr_cnt == LO_LAST);
    assign load_begin  = start && ((state == ST_IDLE) || (state == ST_DONE));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode. abort outranks the terminal handshake while loading.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD_HI;
            ST_LOAD_HI: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (hi_last) state_nxt = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (lo_last) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address counter. It restarts at each load and again at the HI->LO handoff.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                addr_cnt <= '0;
        else if (load_begin || hi_last || lo_last) addr_cnt <= '0;
        else if (xfer)                           addr_cnt <= addr_cnt + 1'b1;
    end

    // SRAM write ports, registered one cycle behind the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_we    <= 1'b0;
            hi_addr  <= '0;
            hi_wdata <= '0;
            lo_we    <= 1'b0;
            lo_addr  <= '0;
            lo_wdata <= '0;
        end else begin
            hi_we <= xfer_hi;
            lo_we <= xfer_lo;
            if (xfer_hi) begin
                hi_addr  <= addr_cnt[HI_AW-1:0];
                hi_wdata <= s_if.s_data;
            end
            if (xfer_lo) begin
                lo_addr  <= addr_cnt[LO_AW-1:0];
                lo_wdata <= s_if.s_data;
            end
        end
    end

    // Per-table checksums. They update with the write and hold through an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_sum <= '0;
            lo_sum <= '0;
        end else if (load_begin) begin
            hi_sum <= '0;
            lo_sum <= '0;
        end else begin
            if (xfer_hi) hi_sum <= hi_sum + 32'(s_if.s_data);
            if (xfer_lo) lo_sum <= lo_sum + 32'(s_if.s_data);
        end
    end

    // done rises the cycle after DONE is entered, which is after the final LO
    // write has landed. It stays set until the next load begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   done <= 1'b0;
        else if (load_begin)        done <= 1'b0;
        else if (state == ST_DONE)  done <= 1'b1;
    end

endmodule

// File: tb/tb_sram_exp_table_writer.sv
// Directed bench for the exp() table writer.
// The main instance uses small tables (16 HI / 32 LO words). A second instance
// uses the default widths and gets a short load-and-abort sequence.
module tb_sram_exp_table_writer;
    import sram_exp_pkg::*;

    localparam int HI_AW = 4;
    localparam int LO_AW = 5;
    localparam int HI_N  = 1 << HI_AW;
    localparam int LO_N  = 1 << LO_AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic             hi_we, lo_we, busy, done;
    logic [HI_AW-1:0] hi_addr;
    logic [LO_AW-1:0] lo_addr;
    logic [31:0]      hi_wdata, lo_wdata, hi_sum, lo_sum;

    logic        dd_start = 1'b0;
    logic        dd_abort = 1'b0;
    logic        dd_hi_we, dd_lo_we, dd_busy, dd_done;
    logic [15:0] dd_hi_addr;
    logic [16:0] dd_lo_addr;
    logic [31:0] dd_hi_wdata, dd_lo_wdata, dd_hi_sum, dd_lo_sum;

    int tests    = 0;
    int failures = 0;

    logic [31:0] hi_mem [HI_N];
    logic [31:0] lo_mem [LO_N];
    int          hi_wr_cnt = 0;
    int          lo_wr_cnt = 0;
    logic        prev_hs   = 1'b0;

    sram_exp_table_writer_if #(.DW(32)) s_if ();
    sram_exp_table_writer_if #(.DW(32)) dd_if ();

    sram_exp_table_writer #(.HI_AW(HI_AW), .LO_AW(LO_AW), .DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .s_if(s_if),
        .hi_we(hi_we), .hi_addr(hi_addr), .hi_wdata(hi_wdata),
        .lo_we(lo_we), .lo_addr(lo_addr), .lo_wdata(lo_wdata),
        .busy(busy), .done(done), .hi_sum(hi_sum), .lo_sum(lo_sum)
    );

    sram_exp_table_writer dut_default (
        .clk(clk), .rst(rst), .start(dd_start), .abort(dd_abort), .s_if(dd_if),
        .hi_we(dd_hi_we), .hi_addr(dd_hi_addr), .hi_wdata(dd_hi_wdata),
        .lo_we(dd_lo_we), .lo_addr(dd_lo_addr), .lo_wdata(dd_lo_wdata),
        .busy(dd_busy), .done(dd_done), .hi_sum(dd_hi_sum), .lo_sum(dd_lo_sum)
    );

    // Free-running clock with posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture SRAM writes on the falling edge. Every write enable must follow a handshake.
    always @(negedge clk) begin
        if (!rst) begin
            prev_hs = 1'b0;
        end else begin
            check_output("we_exclusive", 64'(hi_we & lo_we), 64'd0);
            check_output("we_follows_hs", 64'(hi_we | lo_we), 64'(prev_hs));
            if (hi_we === 1'b1) begin
                hi_mem[hi_addr] = hi_wdata;
                hi_wr_cnt++;
            end
            if (lo_we === 1'b1) begin
                lo_mem[lo_addr] = lo_wdata;
                lo_wr_cnt++;
            end
            prev_hs = s_if.s_valid & s_if.s_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < HI_N; i++) hi_mem[i] = '0;
        for (int i = 0; i < LO_N; i++) lo_mem[i] = '0;
        hi_wr_cnt = 0;
        lo_wr_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Stream n entries base, base+step, ... with optional random idle gaps.
    task automatic apply_stimulus(input int n, input logic [31:0] base,
                                  input logic [31:0] step, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_if.s_valid = 1'b0;
                    s_if.s_data  = $urandom;
                    tick();
                end
            end
            check_output("s_ready_streaming", 64'(s_if.s_ready), 64'd1);
            s_if.s_valid = 1'b1;
            s_if.s_data  = base + step * 32'(i);
            tick();
        end
        s_if.s_valid = 1'b0;
    endtask

    // Compare the captured image against entries 1..48 in address order.
    task automatic check_tables();
        check_output("hi_write_count", 64'(hi_wr_cnt), 64'(HI_N));
        check_output("lo_write_count", 64'(lo_wr_cnt), 64'(LO_N));
        for (int i = 0; i < HI_N; i++) check_output("hi_mem", 64'(hi_mem[i]), 64'(i + 1));
        for (int i = 0; i < LO_N; i++) check_output("lo_mem", 64'(lo_mem[i]), 64'(HI_N + i + 1));
    endtask

    // Check the end of a full load: the last LO write, then done one cycle later.
    task automatic check_load_end();
        check_output("last_lo_we", 64'(lo_we), 64'd1);
        check_output("last_lo_addr", 64'(lo_addr), 64'd31);
        check_output("last_lo_wdata", 64'(lo_wdata), 64'd48);
        check_output("done_not_yet", 64'(done), 64'd0);
        check_output("busy_after_last", 64'(busy), 64'd0);
        check_output("hi_sum_full", 64'(hi_sum), 64'd136);
        check_output("lo_sum_full", 64'(lo_sum), 64'd1040);
        tick();
        check_output("done_set", 64'(done), 64'd1);
        check_output("lo_we_idle", 64'(lo_we), 64'd0);
        check_tables();
    endtask

    initial begin
        s_if.s_valid  = 1'b0;
        s_if.s_data   = '0;
        dd_if.s_valid = 1'b0;
        dd_if.s_data  = '0;
        clear_model();

        // Reset state.
        #12;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_ready", 64'(s_if.s_ready), 64'd0);
        check_output("rst_hi_sum", 64'(hi_sum), 64'd0);
        check_output("rst_lo_addr", 64'(lo_addr), 64'd0);
        #10 rst = 1'b1;
        tick();

        // Test 1: full load with valid held high.
        $display("[TB] test 1: continuous load");
        pulse_start();
        check_output("t1_busy", 64'(busy), 64'd1);
        apply_stimulus(HI_N + LO_N, 32'd1, 32'd1, 1'b0);
        check_load_end();

        // Test 2: same stream with random valid gaps.
        $display("[TB] test 2: load with gaps");
        clear_model();
        pulse_start();
        check_output("t2_sum_clear", 64'(hi_sum), 64'd0);
        check_output("t2_done_clear", 64'(done), 64'd0);
        apply_stimulus(HI_N + LO_N, 32'd1, 32'd1, 1'b1);
        check_load_end();

        // Test 3: abort after 7 HI handshakes, then restart.
        $display("[TB] test 3: abort");
        clear_model();
        pulse_start();
        apply_stimulus(7, 32'd1, 32'd1, 1'b0);
        pulse_abort();
        check_output("t3_busy", 64'(busy), 64'd0);
        check_output("t3_done", 64'(done), 64'd0);
        check_output("t3_ready", 64'(s_if.s_ready), 64'd0);
        check_output("t3_hi_sum_hold", 64'(hi_sum), 64'd28);
        tick();
        check_output("t3_hi_writes", 64'(hi_wr_cnt), 64'd7);
        check_output("t3_lo_writes", 64'(lo_wr_cnt), 64'd0);
        check_output("t3_hi_mem6", 64'(hi_mem[6]), 64'd7);
        check_output("t3_hi_mem7", 64'(hi_mem[7]), 64'd0);
        pulse_start();
        check_output("t3_restart_sum", 64'(hi_sum), 64'd0);
        apply_stimulus(1, 32'd100, 32'd0, 1'b0);
        check_output("t3_restart_we", 64'(hi_we), 64'd1);
        check_output("t3_restart_addr", 64'(hi_addr), 64'd0);
        check_output("t3_restart_sum2", 64'(hi_sum), 64'd100);
        pulse_abort();

        // Test 4: a start pulse during LOAD_LO is ignored.
        $display("[TB] test 4: start ignored while loading");
        clear_model();
        pulse_start();
        apply_stimulus(HI_N + 4, 32'd1, 32'd1, 1'b0);
        pulse_start();
        check_output("t4_busy", 64'(busy), 64'd1);
        check_output("t4_lo_sum_kept", 64'(lo_sum), 64'd74);
        apply_stimulus(LO_N - 4, 32'd21, 32'd1, 1'b0);
        check_load_end();

        // Test 5: asynchronous reset mid-LOAD_LO.
        $display("[TB] test 5: async reset");
        pulse_start();
        apply_stimulus(HI_N + 4, 32'd1, 32'd1, 1'b0);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'd99;
        #2 rst = 1'b0;
        #1;
        check_output("t5_lo_we", 64'(lo_we), 64'd0);
        check_output("t5_lo_addr", 64'(lo_addr), 64'd0);
        check_output("t5_lo_wdata", 64'(lo_wdata), 64'd0);
        check_output("t5_hi_addr", 64'(hi_addr), 64'd0);
        check_output("t5_hi_wdata", 64'(hi_wdata), 64'd0);
        check_output("t5_hi_sum", 64'(hi_sum), 64'd0);
        check_output("t5_lo_sum", 64'(lo_sum), 64'd0);
        check_output("t5_busy", 64'(busy), 64'd0);
        check_output("t5_ready", 64'(s_if.s_ready), 64'd0);
        s_if.s_valid = 1'b0;
        #3 rst = 1'b1;
        tick();
        check_output("t5_ready_after", 64'(s_if.s_ready), 64'd0);
        tick();
        check_output("t5_ready_after2", 64'(s_if.s_ready), 64'd0);
        check_output("t5_done_after", 64'(done), 64'd0);

        // Test 6: checksum wraps modulo 2^32.
        $display("[TB] test 6: checksum wrap");
        pulse_start();
        apply_stimulus(HI_N, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check_output("t6_hi_sum_wrap", 64'(hi_sum), 64'hFFFF_FFF0);
        check_output("t6_in_lo", 64'(busy), 64'd1);
        pulse_abort();

        // Default-width instance: a short HI load, then abort.
        $display("[TB] default widths");
        dd_start = 1'b1;
        tick();
        dd_start = 1'b0;
        check_output("dd_busy", 64'(dd_busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            dd_if.s_valid = 1'b1;
            dd_if.s_data  = 32'(5 + i);
            tick();
        end
        dd_if.s_valid = 1'b0;
        check_output("dd_hi_we", 64'(dd_hi_we), 64'd1);
        check_output("dd_hi_addr", 64'(dd_hi_addr), 64'd2);
        check_output("dd_hi_wdata", 64'(dd_hi_wdata), 64'd7);
        check_output("dd_hi_sum", 64'(dd_hi_sum), 64'd18);
        dd_abort = 1'b1;
        tick();
        dd_abort = 1'b0;
        check_output("dd_busy_abort", 64'(dd_busy), 64'd0);
        check_output("dd_done_abort", 64'(dd_done), 64'd0);
        check_output("dd_sum_hold", 64'(dd_hi_sum), 64'd18);
        check_output("dd_lo_we", 64'(dd_lo_we), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
